// File: rtl/pong_pkg.sv
// Shared Pong definitions: move-command codes (same encoding the AI block emits),
// the screen-height default and the paddle motion state encoding.
package pong_pkg;

    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_DOWN = 2'b01;

    localparam int SCREEN_H_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_motion_ctrl_if.sv
// Command/position bundle between a paddle driver (AI or button decoder) and
// paddle_motion_ctrl, plus the motion FSM state for observation.
interface paddle_motion_ctrl_if;
    import pong_pkg::*;

    // frame_tick is a one-cycle strobe with no back-pressure: move_cmd is only
    // meaningful in a cycle where frame_tick is high and is consumed that cycle.
    logic [1:0]    move_cmd;
    logic          frame_tick;
    logic [9:0]    paddle_pos;
    logic [9:0]    paddle_height;
    logic          at_top;
    logic          at_bottom;
    logic          moving;
    paddle_state_e dbg_state;

    modport master (
        output move_cmd, frame_tick,
        input  paddle_pos, paddle_height, at_top, at_bottom, moving, dbg_state
    );

    modport slave (
        input  move_cmd, frame_tick,
        output paddle_pos, paddle_height, at_top, at_bottom, moving, dbg_state
    );

endinterface

// File: rtl/paddle_speed_ramp.sv
// Per-frame speed ramp: speed climbs by one every ACCEL_FRAMES ticks in the same
// direction, up to MAX_SPEED. restart = new direction, hold = no move command.
module paddle_speed_ramp #(
    parameter int MAX_SPEED    = 6,
    parameter int ACCEL_FRAMES = 4,
    parameter int SPEED_W      = $clog2(MAX_SPEED + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               restart,
    input  logic               hold,
    output logic [SPEED_W-1:0] speed
);

    localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic [CNT_W-1:0]   ACCEL_C = CNT_W'(ACCEL_FRAMES);
    localparam logic [SPEED_W-1:0] MAX_C   = SPEED_W'(MAX_SPEED);
    // A restart tick is itself the first tick of the ramp, so with a one-frame
    // ramp it already completes a step.
    localparam logic [CNT_W-1:0]   CNT_RESTART   = (ACCEL_FRAMES <= 1) ? CNT_W'(0) : CNT_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_RESTART =
        (ACCEL_FRAMES <= 1 && MAX_SPEED >= 2) ? SPEED_W'(2) : SPEED_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            speed <= '0;
        end else if (tick) begin
            if (hold) begin
                cnt   <= '0;
                speed <= '0;
            end else if (restart) begin
                cnt   <= CNT_RESTART;
                speed <= SPEED_RESTART;
            end else if (cnt_inc >= ACCEL_C) begin
                cnt <= '0;
                if (speed < MAX_C) speed <= speed + 1'b1;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Paddle position owner: moves once per frame with a speed ramp and wall clamp.
// Optional idle drift back to centre is enabled by defining PADDLE_AUTO_CENTER_EN.
module paddle_motion_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PADDLE_H     = 80,
    parameter int Y_INIT       = 200,
    parameter int MAX_SPEED    = 6,
    parameter int ACCEL_FRAMES = 4,
    parameter int IDLE_TIMEOUT = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    paddle_motion_ctrl_if.slave   bus
);

    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam logic [9:0]  LIMIT_P  = 10'(SCREEN_H - PADDLE_H);
    localparam logic [10:0] LIMIT_W  = 11'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]  Y_INIT_P = 10'(Y_INIT);

    paddle_state_e      state;
    paddle_state_e      next_state;
    logic [9:0]         pos_q;
    logic [9:0]         next_pos;
    logic               at_top_q, at_bottom_q, moving_q;
    logic               is_up, is_dn, restart, hold;
    logic [SPEED_W-1:0] speed;
    logic [10:0]        pos_w, step_w, sum_w;

    assign is_up   = (bus.move_cmd == CMD_UP);
    assign is_dn   = (bus.move_cmd == CMD_DOWN);
    assign hold    = !is_up && !is_dn;
    assign restart = (is_up && state != ST_UP) || (is_dn && state != ST_DOWN);

    paddle_speed_ramp #(
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES),
        .SPEED_W      (SPEED_W)
    ) u_speed_ramp (
        .clk     (clk),
        .reset   (reset),
        .tick    (bus.frame_tick),
        .restart (restart),
        .hold    (hold),
        .speed   (speed)
    );

`ifdef PADDLE_AUTO_CENTER_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [9:0]        CENTER_P = 10'((SCREEN_H - PADDLE_H) / 2);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (bus.frame_tick) begin
            if (!hold)                    idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
        end
    end
`endif

    // A direction change applies 1 px this tick; the ramp register then holds
    // the speed for the following tick.
    always_comb begin
        pos_w      = {1'b0, pos_q};
        step_w     = restart ? 11'd1 : 11'(speed);
        sum_w      = pos_w + step_w;
        next_state = ST_IDLE;
        next_pos   = pos_q;
        if (is_up) begin
            next_state = ST_UP;
            next_pos   = (pos_w < step_w) ? 10'd0 : pos_q - step_w[9:0];
        end else if (is_dn) begin
            next_state = ST_DOWN;
            next_pos   = (sum_w > LIMIT_W) ? LIMIT_P : sum_w[9:0];
        end else begin
`ifdef PADDLE_AUTO_CENTER_EN
            if (idle_cnt == IDLE_MAX) begin
                if (pos_q < CENTER_P)      next_pos = pos_q + 10'd1;
                else if (pos_q > CENTER_P) next_pos = pos_q - 10'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pos_q       <= Y_INIT_P;
            at_top_q    <= 1'b0;
            at_bottom_q <= 1'b0;
            moving_q    <= 1'b0;
        end else if (bus.frame_tick) begin
            state       <= next_state;
            pos_q       <= next_pos;
            at_top_q    <= (next_pos == 10'd0);
            at_bottom_q <= (next_pos == LIMIT_P);
            moving_q    <= (next_state != ST_IDLE);
        end
    end

    assign bus.paddle_pos    = pos_q;
    assign bus.paddle_height = 10'(PADDLE_H);
    assign bus.at_top        = at_top_q;
    assign bus.at_bottom     = at_bottom_q;
    assign bus.moving        = moving_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: directed scenarios plus randomized command bursts,
// all checked against a run-length speed model of the paddle.
module tb_paddle_motion_ctrl;

    localparam int SCREEN_H     = 480;
    localparam int PADDLE_H     = 80;
    localparam int Y_INIT       = 200;
    localparam int MAX_SPEED    = 6;
    localparam int ACCEL_FRAMES = 4;
    localparam int IDLE_TIMEOUT = 30;
    localparam int LIMIT        = SCREEN_H - PADDLE_H;
    localparam int CENTER       = LIMIT / 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // Reference model state
    int m_pos;
    int m_dir;   // -1 up, +1 down, 0 idle
    int m_run;   // ticks so far in the current direction
    int m_idle;  // consecutive idle ticks

    paddle_motion_ctrl_if bus ();

    paddle_motion_ctrl #(
        .SCREEN_H     (SCREEN_H),
        .PADDLE_H     (PADDLE_H),
        .Y_INIT       (Y_INIT),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = Y_INIT;
        m_dir  = 0;
        m_run  = 0;
        m_idle = 0;
    endtask

    // Speed is a pure function of how many ticks the current direction has run.
    task automatic model_tick(input logic [1:0] cmd);
        int d;
        int spd;
        if (cmd == 2'b10 || cmd == 2'b01) begin
            d     = (cmd == 2'b10) ? -1 : 1;
            m_run = (d == m_dir) ? m_run + 1 : 1;
            m_dir = d;
            spd   = 1 + (m_run - 1) / ACCEL_FRAMES;
            if (spd > MAX_SPEED) spd = MAX_SPEED;
            m_pos = m_pos + d * spd;
            if (m_pos < 0)     m_pos = 0;
            if (m_pos > LIMIT) m_pos = LIMIT;
            m_idle = 0;
        end else begin
`ifdef PADDLE_AUTO_CENTER_EN
            if (m_idle >= IDLE_TIMEOUT) begin
                if (m_pos < CENTER)      m_pos = m_pos + 1;
                else if (m_pos > CENTER) m_pos = m_pos - 1;
            end
`endif
            m_dir  = 0;
            m_run  = 0;
            m_idle = m_idle + 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pos"},       32'(bus.paddle_pos), 32'(m_pos));
        check({tag, ".at_top"},    32'(bus.at_top),     32'(m_pos == 0));
        check({tag, ".at_bottom"}, 32'(bus.at_bottom),  32'(m_pos == LIMIT));
        check({tag, ".moving"},    32'(bus.moving),     32'(m_dir != 0));
        check({tag, ".in_range"},  32'(bus.paddle_pos <= 10'(LIMIT)), 32'd1);
    endtask

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.move_cmd   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_tick(input logic [1:0] cmd, input string tag);
        @(negedge clk);
        bus.move_cmd   = cmd;
        bus.frame_tick = 1'b1;
        model_tick(cmd);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.move_cmd   = 2'($urandom);
        check_outputs(tag);
    endtask

    logic [1:0] cmd;
    int         len, gap, pos_before;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset          = 1'b1;
        bus.move_cmd   = 2'b00;
        bus.frame_tick = 1'b0;
        model_reset();

        // Reset values
        do_reset();
        check_outputs("reset");
        check("reset.height", 32'(bus.paddle_height), 32'(PADDLE_H));
        check("reset.pos_200", 32'(bus.paddle_pos), 32'd200);

        // 12 ticks down: speeds 1x4, 2x4, 3x4
        for (int i = 0; i < 12; i++) drive_tick(2'b01, "down12");
        check("down12.pos_224", 32'(bus.paddle_pos), 32'd224);

        // Async reset mid-motion takes effect without a clock edge
        drive_tick(2'b01, "down13");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset.pos",    32'(bus.paddle_pos), 32'(Y_INIT));
        check("async_reset.moving", 32'(bus.moving),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs("after_reset");

        // Up into the top wall and stay pinned
        for (int i = 0; i < 60; i++) drive_tick(2'b10, "up60");
        check("up60.pos_0",  32'(bus.paddle_pos), 32'd0);
        check("up60.at_top", 32'(bus.at_top),     32'd1);

        // Down into the bottom wall
        for (int i = 0; i < 80; i++) drive_tick(2'b01, "down80");
        check("down80.at_bottom", 32'(bus.at_bottom), 32'd1);

        // Reversal restarts the ramp at 1 px
        do_reset();
        for (int i = 0; i < 8; i++) drive_tick(2'b01, "rev_down");
        check("rev.pos_212", 32'(bus.paddle_pos), 32'd212);
        drive_tick(2'b10, "rev_up1");
        check("rev.pos_211", 32'(bus.paddle_pos), 32'd211);
        for (int i = 0; i < 4; i++) drive_tick(2'b10, "rev_up");

        // None command goes idle; off-tick command changes are ignored
        pos_before = int'(bus.paddle_pos);
        drive_tick(2'b11, "none11");
        check("none11.pos_hold", 32'(bus.paddle_pos), 32'(pos_before));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.move_cmd = 2'(i);
        end
        check_outputs("no_tick");

        // Long idle at the top wall (drift only with auto-centre)
        do_reset();
        for (int i = 0; i < 60; i++) drive_tick(2'b10, "ac_up");
        for (int i = 0; i < 250; i++) drive_tick(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, "idle");
`ifdef PADDLE_AUTO_CENTER_EN
        check("idle.pos_center", 32'(bus.paddle_pos), 32'(CENTER));
`else
        check("idle.pos_hold0", 32'(bus.paddle_pos), 32'd0);
`endif

        // Randomized command bursts with gaps between ticks
        do_reset();
        for (int b = 0; b < 120; b++) begin
            cmd = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                drive_tick(cmd, "rand");
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.move_cmd = 2'($urandom);
                end
                if (gap > 0) check_outputs("rand_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
